draw_scheduler: RTL and testbench

DRAW_SCHEDULER -- requirements
Module: draw_scheduler

---
 rtl/draw_scheduler.sv | 173 +++++++++++++++++
 tb/tb_draw_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/draw_scheduler.sv
// Frame draw scheduler: sequences the car, tower and laser engines and muxes the
// active engine onto a registered framebuffer write port. Watchdog: DRAW_WATCHDOG_EN.
module draw_scheduler #(
    parameter logic [15:0] WD_LIMIT = 16'd40000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    output logic        car_start,
    output logic        tower_start,
    output logic        laser_start,
    input  logic        car_done,
    input  logic        tower_done,
    input  logic        laser_done,
    input  logic        car_wren,
    input  logic        tower_wren,
    input  logic        laser_wren,
    input  logic [14:0] car_coord,
    input  logic [14:0] tower_coord,
    input  logic [14:0] laser_coord,
    input  logic [8:0]  car_colour,
    input  logic [8:0]  tower_colour,
    input  logic [8:0]  laser_colour,
    output logic        vga_wren,
    output logic [14:0] vga_coord,
    output logic [8:0]  vga_colour,
    output logic [1:0]  phase,
    output logic        busy,
    output logic [7:0]  overrun_cnt,
    output logic        timeout
);

    if (WD_LIMIT == 16'd0) begin : g_bad_limit
        $error("draw_scheduler: WD_LIMIT must be nonzero");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CAR   = 2'd1,
        S_TOWER = 2'd2,
        S_LASER = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        car_start_q, car_start_d;
    logic        tower_start_q, tower_start_d;
    logic        laser_start_q, laser_start_d;
    logic        vga_wren_q, vga_wren_d;
    logic [14:0] vga_coord_q, vga_coord_d;
    logic [8:0]  vga_colour_q, vga_colour_d;
    logic [7:0]  overrun_q, overrun_d;
    logic        phase_done;
    logic        advance;

    always_comb begin
        phase_done = 1'b0;
        unique case (state_q)
            S_CAR:   phase_done = car_done;
            S_TOWER: phase_done = tower_done;
            S_LASER: phase_done = laser_done;
            default: phase_done = 1'b0;
        endcase
    end

`ifdef DRAW_WATCHDOG_EN
    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        timeout_q, timeout_d;
    logic        wd_expire;

    // The entry cycle counts as cycle 1, so expiry fires on count LIMIT-1.
    assign wd_expire = (state_q != S_IDLE) && (wd_cnt_q >= WD_LIMIT - 16'd1);
    assign advance   = phase_done | wd_expire;

    always_comb begin
        timeout_d = timeout_q | (wd_expire & ~phase_done);
        wd_cnt_d  = '0;
        if (state_d == state_q && state_q != S_IDLE) begin
            wd_cnt_d = wd_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign advance = phase_done;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (frame_tick) state_d = S_CAR;
            S_CAR:   if (advance)    state_d = S_TOWER;
            S_TOWER: if (advance)    state_d = S_LASER;
            S_LASER: if (advance)    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        car_start_d   = (state_d == S_CAR)   && (state_q != S_CAR);
        tower_start_d = (state_d == S_TOWER) && (state_q != S_TOWER);
        laser_start_d = (state_d == S_LASER) && (state_q != S_LASER);

        // Ticks seen while not IDLE are dropped, including the LASER->IDLE cycle.
        overrun_d = overrun_q;
        if (frame_tick && state_q != S_IDLE && overrun_q != 8'hFF) begin
            overrun_d = overrun_q + 8'd1;
        end

        vga_wren_d   = 1'b0;
        vga_coord_d  = '0;
        vga_colour_d = '0;
        unique case (state_q)
            S_CAR: begin
                vga_wren_d   = car_wren;
                vga_coord_d  = car_coord;
                vga_colour_d = car_colour;
            end
            S_TOWER: begin
                vga_wren_d   = tower_wren;
                vga_coord_d  = tower_coord;
                vga_colour_d = tower_colour;
            end
            S_LASER: begin
                vga_wren_d   = laser_wren;
                vga_coord_d  = laser_coord;
                vga_colour_d = laser_colour;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            car_start_q   <= 1'b0;
            tower_start_q <= 1'b0;
            laser_start_q <= 1'b0;
            vga_wren_q    <= 1'b0;
            vga_coord_q   <= '0;
            vga_colour_q  <= '0;
            overrun_q     <= '0;
        end else begin
            state_q       <= state_d;
            car_start_q   <= car_start_d;
            tower_start_q <= tower_start_d;
            laser_start_q <= laser_start_d;
            vga_wren_q    <= vga_wren_d;
            vga_coord_q   <= vga_coord_d;
            vga_colour_q  <= vga_colour_d;
            overrun_q     <= overrun_d;
        end
    end

    assign car_start   = car_start_q;
    assign tower_start = tower_start_q;
    assign laser_start = laser_start_q;
    assign vga_wren    = vga_wren_q;
    assign vga_coord   = vga_coord_q;
    assign vga_colour  = vga_colour_q;
    assign phase       = state_q;
    assign busy        = (state_q != S_IDLE);
    assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler; a second short-limit instance is checked
// when DRAW_WATCHDOG_EN is defined.
module tb_draw_scheduler;

    logic        clk;
    logic        reset;
    logic        frame_tick;
    logic        car_start, tower_start, laser_start;
    logic        car_done, tower_done, laser_done;
    logic        car_wren, tower_wren, laser_wren;
    logic [14:0] car_coord, tower_coord, laser_coord;
    logic [8:0]  car_colour, tower_colour, laser_colour;
    logic        vga_wren;
    logic [14:0] vga_coord;
    logic [8:0]  vga_colour;
    logic [1:0]  phase;
    logic        busy;
    logic [7:0]  overrun_cnt;
    logic        timeout;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    draw_scheduler #(.WD_LIMIT(16'd40000)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .car_start(car_start), .tower_start(tower_start), .laser_start(laser_start),
        .car_done(car_done), .tower_done(tower_done), .laser_done(laser_done),
        .car_wren(car_wren), .tower_wren(tower_wren), .laser_wren(laser_wren),
        .car_coord(car_coord), .tower_coord(tower_coord), .laser_coord(laser_coord),
        .car_colour(car_colour), .tower_colour(tower_colour), .laser_colour(laser_colour),
        .vga_wren(vga_wren), .vga_coord(vga_coord), .vga_colour(vga_colour),
        .phase(phase), .busy(busy), .overrun_cnt(overrun_cnt), .timeout(timeout)
    );

`ifdef DRAW_WATCHDOG_EN
    logic        w_car_start, w_tower_start, w_laser_start;
    logic        w_vga_wren;
    logic [14:0] w_vga_coord;
    logic [8:0]  w_vga_colour;
    logic [1:0]  w_phase;
    logic        w_busy;
    logic [7:0]  w_overrun_cnt;
    logic        w_timeout;

    draw_scheduler #(.WD_LIMIT(16'd10)) dut_wd (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .car_start(w_car_start), .tower_start(w_tower_start), .laser_start(w_laser_start),
        .car_done(car_done), .tower_done(tower_done), .laser_done(laser_done),
        .car_wren(car_wren), .tower_wren(tower_wren), .laser_wren(laser_wren),
        .car_coord(car_coord), .tower_coord(tower_coord), .laser_coord(laser_coord),
        .car_colour(car_colour), .tower_colour(tower_colour), .laser_colour(laser_colour),
        .vga_wren(w_vga_wren), .vga_coord(w_vga_coord), .vga_colour(w_vga_colour),
        .phase(w_phase), .busy(w_busy), .overrun_cnt(w_overrun_cnt), .timeout(w_timeout)
    );
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        frame_tick = 1'b0;
        car_done = 1'b0;  tower_done = 1'b0;  laser_done = 1'b0;
        car_wren = 1'b0;  tower_wren = 1'b0;  laser_wren = 1'b0;
        car_coord = '0;   tower_coord = '0;   laser_coord = '0;
        car_colour = '0;  tower_colour = '0;  laser_colour = '0;

        tick();
        tick();
        chk("rst_phase", phase, 0);
        chk("rst_busy", busy, 0);
        chk("rst_starts", {car_start, tower_start, laser_start}, 0);
        chk("rst_vga_wren", vga_wren, 0);
        chk("rst_overrun", overrun_cnt, 0);
        chk("rst_timeout", timeout, 0);
        reset = 1'b0;

        // Full frame: done returned 5, 3, 7 cycles after each start
        frame_tick = 1'b1;                 // cycle 0
        tick();  frame_tick = 1'b0;        // cycle 1
        chk("c1_car_start", car_start, 1);
        chk("c1_phase", phase, 1);
        chk("c1_busy", busy, 1);
        tick();                            // cycle 2
        chk("c2_car_start_low", car_start, 0);
        repeat (4) tick();                 // cycle 6
        car_done = 1'b1;
        tick();  car_done = 1'b0;          // cycle 7
        chk("c7_tower_start", tower_start, 1);
        chk("c7_phase", phase, 2);
        repeat (3) tick();                 // cycle 10
        tower_done = 1'b1;
        tick();  tower_done = 1'b0;        // cycle 11
        chk("c11_laser_start", laser_start, 1);
        chk("c11_phase", phase, 3);
        repeat (7) tick();                 // cycle 18
        chk("c18_phase", phase, 3);
        laser_done = 1'b1;
        tick();  laser_done = 1'b0;        // cycle 19
        chk("c19_phase", phase, 0);
        chk("c19_busy", busy, 0);
        chk("c19_overrun", overrun_cnt, 0);

        // Write muxing: only the active engine reaches the framebuffer
        frame_tick = 1'b1;
        tick();  frame_tick = 1'b0;
        car_wren = 1'b1;  car_coord = 15'h1234;  car_colour = 9'h1FF;
        tower_wren = 1'b1; tower_coord = 15'h7777; tower_colour = 9'h0AA;
        tick();
        chk("wr_vga_wren", vga_wren, 1);
        chk("wr_vga_coord", vga_coord, 15'h1234);
        chk("wr_vga_colour", vga_colour, 9'h1FF);
        car_wren = 1'b0;
        tick();
        chk("wr_inactive_wren", vga_wren, 0);

        // Write in the done cycle is still forwarded
        car_wren = 1'b1;  car_coord = 15'h0ABC;  car_colour = 9'h055;  car_done = 1'b1;
        tower_wren = 1'b0;
        tick();
        car_done = 1'b0;  car_wren = 1'b0;
        chk("last_wr_phase", phase, 2);
        chk("last_wr_wren", vga_wren, 1);
        chk("last_wr_coord", vga_coord, 15'h0ABC);
        chk("last_wr_colour", vga_colour, 9'h055);

        // Stuck in TOWER: 300 dropped ticks, stray done pulses ignored
        frame_tick = 1'b1;  laser_done = 1'b1;  car_done = 1'b1;
        repeat (3) tick();
        chk("ovr_3", overrun_cnt, 3);
        repeat (297) tick();
        frame_tick = 1'b0;  laser_done = 1'b0;  car_done = 1'b0;
        chk("ovr_sat", overrun_cnt, 8'hFF);
        chk("stray_done_phase", phase, 2);
        chk("no_timeout", timeout, 0);

        tower_done = 1'b1;
        tick();  tower_done = 1'b0;
        chk("to_laser", phase, 3);
        laser_wren = 1'b1;  laser_coord = 15'h2345;  laser_colour = 9'h123;
        tick();
        chk("laser_wr_coord", vga_coord, 15'h2345);

        // Asynchronous reset mid-LASER while writing
        #3 reset = 1'b1;
        #1;
        chk("arst_phase", phase, 0);
        chk("arst_busy", busy, 0);
        chk("arst_vga_wren", vga_wren, 0);
        chk("arst_vga_coord", vga_coord, 0);
        chk("arst_overrun", overrun_cnt, 0);
        #1 reset = 1'b0;
        laser_done = 1'b1;
        repeat (3) tick();
        chk("post_rst_phase", phase, 0);
        chk("post_rst_vga_wren", vga_wren, 0);
        laser_done = 1'b0;  laser_wren = 1'b0;

        // Done in the same cycle as start
        frame_tick = 1'b1;
        tick();  frame_tick = 1'b0;
        chk("fast_car_start", car_start, 1);
        car_done = 1'b1;
        tick();  car_done = 1'b0;
        chk("fast_phase", phase, 2);
        chk("fast_tower_start", tower_start, 1);
        chk("fast_car_start_low", car_start, 0);
        tick();
        chk("tower_start_pulse", tower_start, 0);
        tower_done = 1'b1;
        tick();  tower_done = 1'b0;
        chk("fast_laser_start", laser_start, 1);

        // Tick coinciding with LASER->IDLE is dropped
        laser_wren = 1'b1;  laser_coord = 15'h5A5A;  laser_colour = 9'h0F0;
        laser_done = 1'b1;  frame_tick = 1'b1;
        tick();
        laser_wren = 1'b0;  laser_done = 1'b0;  frame_tick = 1'b0;
        chk("edge_phase", phase, 0);
        chk("edge_overrun", overrun_cnt, 1);
        chk("edge_last_coord", vga_coord, 15'h5A5A);
        car_wren = 1'b1;  car_coord = 15'h1111;  car_colour = 9'h1AB;
        tick();
        car_wren = 1'b0;
        chk("idle_phase", phase, 0);
        chk("idle_vga_wren", vga_wren, 0);
        chk("idle_vga_coord", vga_coord, 0);
        chk("idle_vga_colour", vga_colour, 0);

`ifdef DRAW_WATCHDOG_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        frame_tick = 1'b1;
        tick();  frame_tick = 1'b0;
        chk("wd_car_start", w_car_start, 1);
        repeat (9) tick();
        chk("wd_still_car", w_phase, 1);
        chk("wd_timeout_low", w_timeout, 0);
        tick();
        chk("wd_phase", w_phase, 2);
        chk("wd_tower_start", w_tower_start, 1);
        chk("wd_timeout", w_timeout, 1);
        repeat (3) tick();
        chk("wd_timeout_sticky", w_timeout, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
